// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller: FSM states,
// pipe-select values, redirect source encoding and a saturating counter helper.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    SRC_ID = 1'b0,
    SRC_EX = 1'b1
  } src_e;

  localparam logic PIPE_T = 1'b1;
  localparam logic PIPE_N = 1'b0;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, inc};
    return sum[16] ? '1 : sum[15:0];
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_pend_buf.sv
// One-entry pending redirect buffer {pipe, pc, src}; a load always overwrites
// whatever entry is held.
module redirect_pend_buf
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            in_pipe,
  input  logic [PC_W-1:0] in_pc,
  input  src_e            in_src,
  output logic            pipe,
  output logic [PC_W-1:0] pc,
  output src_e            src
);

  logic            pipe_q, pipe_d;
  logic [PC_W-1:0] pc_q, pc_d;
  src_e            src_q, src_d;

  always_comb begin
    pipe_d = pipe_q;
    pc_d   = pc_q;
    src_d  = src_q;
    if (load) begin
      pipe_d = in_pipe;
      pc_d   = in_pc;
      src_d  = in_src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= PIPE_N;
      pc_q   <= '0;
      src_q  <= SRC_ID;
    end else begin
      pipe_q <= pipe_d;
      pc_q   <= pc_d;
      src_q  <= src_d;
    end
  end

  assign pipe = pipe_q;
  assign pc   = pc_q;
  assign src  = src_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates EX/ID redirects onto the T/N pipes with
// stall buffering and an ID hold-off window. Optional stats via REDIRECT_STATS_EN.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_req,
  input  logic            ex_pipe,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            id_req,
  input  logic            id_pipe,
  input  logic [PC_W-1:0] id_pc,
  input  logic            fetch_stall,
  output logic            redir_t,
  output logic            redir_n,
  output logic [PC_W-1:0] redir_pc_t,
  output logic [PC_W-1:0] redir_pc_n,
  output logic            flush_ifid_t,
  output logic            flush_idex_t,
  output logic            flush_ifid_n,
  output logic            flush_idex_n,
  output logic            pipe_valid_t,
  output logic            pipe_valid_n,
  output logic            busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0]     ex_cnt,
  output logic [15:0]     id_cnt,
  output logic [15:0]     drop_cnt
`endif
);

  localparam logic [1:0] HOLD_RELOAD = (HOLD_CYCLES > 0) ? 2'(HOLD_CYCLES - 1) : 2'd0;

  state_e          state_q, state_d;
  logic [1:0]      hold_cnt_q, hold_cnt_d;

  logic            req_vld, req_pipe;
  logic [PC_W-1:0] req_pc;
  src_e            req_src;

  logic            buf_load, buf_pipe;
  logic [PC_W-1:0] buf_pc;
  src_e            buf_src;

  logic            issue, iss_pipe;
  logic [PC_W-1:0] iss_pc;
  src_e            iss_src;

  logic            redir_t_q, redir_t_d, redir_n_q, redir_n_d;
  logic [PC_W-1:0] redir_pc_t_q, redir_pc_t_d, redir_pc_n_q, redir_pc_n_d;
  logic            flush_ifid_t_q, flush_ifid_t_d, flush_idex_t_q, flush_idex_t_d;
  logic            flush_ifid_n_q, flush_ifid_n_d, flush_idex_n_q, flush_idex_n_d;
  logic            pipe_valid_t_q, pipe_valid_t_d, pipe_valid_n_q, pipe_valid_n_d;

  // EX always wins the raw arbitration; whether an ID request survives depends on state.
  always_comb begin
    req_vld  = ex_req | id_req;
    req_pipe = ex_req ? ex_pipe : id_pipe;
    req_pc   = ex_req ? ex_pc : id_pc;
    req_src  = ex_req ? SRC_EX : SRC_ID;
  end

  redirect_pend_buf #(
    .PC_W (PC_W)
  ) u_pend_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .in_pipe (req_pipe),
    .in_pc   (req_pc),
    .in_src  (req_src),
    .pipe    (buf_pipe),
    .pc      (buf_pc),
    .src     (buf_src)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    buf_load   = 1'b0;
    issue      = 1'b0;
    iss_pipe   = req_pipe;
    iss_pc     = req_pc;
    iss_src    = req_src;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (fetch_stall) begin
            buf_load = 1'b1;
            state_d  = PEND;
          end else begin
            issue = 1'b1;
          end
        end
      end
      PEND: begin
        // A fresh EX request on the release cycle bypasses the buffer it would overwrite.
        buf_load = ex_req & fetch_stall;
        if (!fetch_stall) begin
          issue = 1'b1;
          if (!ex_req) begin
            iss_pipe = buf_pipe;
            iss_pc   = buf_pc;
            iss_src  = buf_src;
          end
        end
      end
      HOLD: begin
        if (ex_req) begin
          if (fetch_stall) begin
            buf_load = 1'b1;
            state_d  = PEND;
          end else begin
            issue = 1'b1;
          end
        end else if (hold_cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d    = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      hold_cnt_d = HOLD_RELOAD;
    end
  end

  always_comb begin
    redir_t_d      = issue & (iss_pipe == PIPE_T);
    redir_n_d      = issue & (iss_pipe == PIPE_N);
    redir_pc_t_d   = redir_t_d ? iss_pc : '0;
    redir_pc_n_d   = redir_n_d ? iss_pc : '0;
    flush_ifid_t_d = redir_t_d;
    flush_ifid_n_d = redir_n_d;
    flush_idex_t_d = redir_t_d & (iss_src == SRC_EX);
    flush_idex_n_d = redir_n_d & (iss_src == SRC_EX);
    pipe_valid_t_d = pipe_valid_t_q;
    pipe_valid_n_d = pipe_valid_n_q;
    if (issue && iss_src == SRC_EX) begin
      pipe_valid_t_d = (iss_pipe == PIPE_T);
      pipe_valid_n_d = (iss_pipe == PIPE_N);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      redir_t_q      <= 1'b0;
      redir_n_q      <= 1'b0;
      redir_pc_t_q   <= '0;
      redir_pc_n_q   <= '0;
      flush_ifid_t_q <= 1'b0;
      flush_idex_t_q <= 1'b0;
      flush_ifid_n_q <= 1'b0;
      flush_idex_n_q <= 1'b0;
      pipe_valid_t_q <= 1'b1;
      pipe_valid_n_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      redir_t_q      <= redir_t_d;
      redir_n_q      <= redir_n_d;
      redir_pc_t_q   <= redir_pc_t_d;
      redir_pc_n_q   <= redir_pc_n_d;
      flush_ifid_t_q <= flush_ifid_t_d;
      flush_idex_t_q <= flush_idex_t_d;
      flush_ifid_n_q <= flush_ifid_n_d;
      flush_idex_n_q <= flush_idex_n_d;
      pipe_valid_t_q <= pipe_valid_t_d;
      pipe_valid_n_q <= pipe_valid_n_d;
    end
  end

  assign redir_t      = redir_t_q;
  assign redir_n      = redir_n_q;
  assign redir_pc_t   = redir_pc_t_q;
  assign redir_pc_n   = redir_pc_n_q;
  assign flush_ifid_t = flush_ifid_t_q;
  assign flush_idex_t = flush_idex_t_q;
  assign flush_ifid_n = flush_ifid_n_q;
  assign flush_idex_n = flush_idex_n_q;
  assign pipe_valid_t = pipe_valid_t_q;
  assign pipe_valid_n = pipe_valid_n_q;
  assign busy         = (state_q == PEND);

`ifdef REDIRECT_STATS_EN
  logic [15:0] ex_cnt_q, ex_cnt_d, id_cnt_q, id_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [1:0]  drop_inc;

  // Drops: ID losing to EX or arriving outside IDLE, plus a buffered entry overwritten by EX.
  always_comb begin
    drop_inc   = {1'b0, id_req & (ex_req | (state_q != IDLE))}
               + {1'b0, ex_req & (state_q == PEND)};
    ex_cnt_d   = (issue && iss_src == SRC_EX) ? sat_add16(ex_cnt_q, 2'd1) : ex_cnt_q;
    id_cnt_d   = (issue && iss_src == SRC_ID) ? sat_add16(id_cnt_q, 2'd1) : id_cnt_q;
    drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_cnt_q   <= '0;
      id_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      ex_cnt_q   <= ex_cnt_d;
      id_cnt_q   <= id_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ex_cnt   = ex_cnt_q;
  assign id_cnt   = id_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl (HOLD_CYCLES=2) against a
// transaction-level reference model; covers stats when REDIRECT_STATS_EN is defined.
module tb_fetch_redirect_ctrl;

  localparam int PC_W = 10;
  localparam int HC   = 2;
  localparam int VW   = 2 * PC_W + 9;

  logic            clk, rst;
  logic            ex_req, ex_pipe, id_req, id_pipe, fetch_stall;
  logic [PC_W-1:0] ex_pc, id_pc;
  logic            redir_t, redir_n;
  logic [PC_W-1:0] redir_pc_t, redir_pc_n;
  logic            flush_ifid_t, flush_idex_t, flush_ifid_n, flush_idex_n;
  logic            pipe_valid_t, pipe_valid_n, busy;
`ifdef REDIRECT_STATS_EN
  logic [15:0]     ex_cnt, id_cnt, drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  fetch_redirect_ctrl #(
    .PC_W        (PC_W),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_req       (ex_req),
    .ex_pipe      (ex_pipe),
    .ex_pc        (ex_pc),
    .id_req       (id_req),
    .id_pipe      (id_pipe),
    .id_pc        (id_pc),
    .fetch_stall  (fetch_stall),
    .redir_t      (redir_t),
    .redir_n      (redir_n),
    .redir_pc_t   (redir_pc_t),
    .redir_pc_n   (redir_pc_n),
    .flush_ifid_t (flush_ifid_t),
    .flush_idex_t (flush_idex_t),
    .flush_ifid_n (flush_ifid_n),
    .flush_idex_n (flush_idex_n),
    .pipe_valid_t (pipe_valid_t),
    .pipe_valid_n (pipe_valid_n),
    .busy         (busy)
`ifdef REDIRECT_STATS_EN
    ,
    .ex_cnt       (ex_cnt),
    .id_cnt       (id_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending entry (if any), remaining ID-suppression cycles,
  // sticky pipe-valid flags and event tallies.
  bit              m_pend;
  bit              m_pipe;
  logic [PC_W-1:0] m_pc;
  bit              m_is_ex;
  int              m_hold;
  bit              m_pvt, m_pvn;
  int              m_ex, m_id, m_drop;
  logic [VW-1:0]   exp_vec;

  function automatic logic [VW-1:0] observed();
    return {redir_t, redir_n, redir_pc_t, redir_pc_n, flush_ifid_t, flush_idex_t,
            flush_ifid_n, flush_idex_n, pipe_valid_t, pipe_valid_n, busy};
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_hold  = 0;
    m_pvt   = 1;
    m_pvn   = 1;
    m_ex    = 0;
    m_id    = 0;
    m_drop  = 0;
    exp_vec = {2'b00, {(2*PC_W){1'b0}}, 4'b0000, 2'b11, 1'b0};
  endtask

  task automatic model_step();
    bit              iss, ip, ie, have, np, ne;
    logic [PC_W-1:0] ipc, npc, pct, pcn;
    bit              rt, rn;
    if (!rst) begin
      model_reset();
      return;
    end
    iss = 0; have = 0; ip = 0; ie = 0; ipc = '0; np = 0; ne = 0; npc = '0;
    if (m_pend) begin
      if (id_req) m_drop++;
      if (ex_req) begin
        m_drop++;
        m_pipe = ex_pipe; m_pc = ex_pc; m_is_ex = 1;
      end
      if (!fetch_stall) begin
        iss = 1; ip = m_pipe; ipc = m_pc; ie = m_is_ex;
      end
    end else begin
      if (ex_req) begin
        have = 1; np = ex_pipe; npc = ex_pc; ne = 1;
        if (id_req) m_drop++;
      end else if (id_req) begin
        if (m_hold == 0) begin
          have = 1; np = id_pipe; npc = id_pc; ne = 0;
        end else begin
          m_drop++;
        end
      end
      if (!have && m_hold > 0) m_hold--;
      if (have) begin
        if (fetch_stall) begin
          m_pend = 1; m_pipe = np; m_pc = npc; m_is_ex = ne; m_hold = 0;
        end else begin
          iss = 1; ip = np; ipc = npc; ie = ne;
        end
      end
    end
    if (iss) begin
      m_pend = 0;
      m_hold = HC;
      if (ie) begin
        m_pvt = ip;
        m_pvn = !ip;
        if (m_ex < 65535) m_ex++;
      end else if (m_id < 65535) begin
        m_id++;
      end
    end
    if (m_drop > 65535) m_drop = 65535;
    rt  = iss && ip;
    rn  = iss && !ip;
    pct = rt ? ipc : '0;
    pcn = rn ? ipc : '0;
    exp_vec = {rt, rn, pct, pcn, rt, rt && ie, rn, rn && ie, m_pvt, m_pvn, m_pend};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    ex_req = 0; ex_pipe = 0; ex_pc = '0;
    id_req = 0; id_pipe = 0; id_pc = '0;
    fetch_stall = 0;
  endtask

  task automatic settle();
    clear_inputs();
    for (int i = 0; i < HC + 3; i++) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    model_reset();
    tick();
    tick();
    checks++;
    if (observed() !== {2'b00, {(2*PC_W){1'b0}}, 4'b0000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", observed(),
               {2'b00, {(2*PC_W){1'b0}}, 4'b0000, 2'b11, 1'b0});
    end
    rst = 1;
    tick();
    checks++;
    if (observed() !== exp_vec) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", observed(), exp_vec);
    end
  endtask

  task automatic test_ex_basic();
    settle();
    ex_req = 1; ex_pipe = 0; ex_pc = 10'h12A;
    tick();
    clear_inputs();
    checks++;
    if ({redir_n, redir_pc_n, flush_ifid_n, flush_idex_n, pipe_valid_n, pipe_valid_t, redir_t}
        !== {1'b1, 10'h12A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ex_basic got rn=%b pc=%h fi=%b fx=%b pvn=%b pvt=%b rt=%b exp 1 12a 1 1 1 0 0",
               redir_n, redir_pc_n, flush_ifid_n, flush_idex_n, pipe_valid_n, pipe_valid_t, redir_t);
    end
    checks++;
    if (observed() !== exp_vec) begin
      failures++;
      $display("FAIL ex_basic_model got=%h exp=%h", observed(), exp_vec);
    end
    tick();
    checks++;
    if ({redir_t, redir_n, flush_ifid_n} !== 3'b000) begin
      failures++;
      $display("FAIL ex_strobe_one_cycle got=%b exp=000", {redir_t, redir_n, flush_ifid_n});
    end
  endtask

  task automatic test_priority();
`ifdef REDIRECT_STATS_EN
    logic [15:0] drop_before;
`endif
    settle();
`ifdef REDIRECT_STATS_EN
    drop_before = 16'(m_drop);
`endif
    ex_req = 1; ex_pipe = 1; ex_pc = 10'h040;
    id_req = 1; id_pipe = 0; id_pc = 10'h300;
    tick();
    clear_inputs();
    checks++;
    if ({redir_t, redir_pc_t, redir_n, redir_pc_n, flush_ifid_n}
        !== {1'b1, 10'h040, 1'b0, 10'h000, 1'b0}) begin
      failures++;
      $display("FAIL priority got rt=%b pct=%h rn=%b pcn=%h fin=%b exp 1 040 0 000 0",
               redir_t, redir_pc_t, redir_n, redir_pc_n, flush_ifid_n);
    end
`ifdef REDIRECT_STATS_EN
    checks++;
    if (drop_cnt !== drop_before + 16'd1) begin
      failures++;
      $display("FAIL priority_drop_cnt got=%0d exp=%0d", drop_cnt, drop_before + 16'd1);
    end
`endif
  endtask

  task automatic test_stall_overwrite();
    settle();
    fetch_stall = 1;
    id_req = 1; id_pipe = 1; id_pc = 10'h010;
    tick();
    id_req = 0;
    ex_req = 1; ex_pipe = 1; ex_pc = 10'h020;
    tick();
    ex_req = 0;
    tick();
    checks++;
    if ({busy, redir_t, redir_n} !== 3'b100) begin
      failures++;
      $display("FAIL stall_busy got=%b exp=100", {busy, redir_t, redir_n});
    end
    fetch_stall = 0;
    tick();
    checks++;
    if ({redir_t, redir_pc_t, flush_idex_t, busy} !== {1'b1, 10'h020, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL stall_issue got rt=%b pct=%h fxt=%b busy=%b exp 1 020 1 0",
               redir_t, redir_pc_t, flush_idex_t, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({redir_t, redir_n} !== 2'b00) begin
        failures++;
        $display("FAIL stall_no_stale_issue got=%b exp=00 pct=%h", {redir_t, redir_n}, redir_pc_t);
      end
    end
  endtask

  task automatic test_hold();
    settle();
    ex_req = 1; ex_pipe = 0; ex_pc = 10'h055;
    tick();
    ex_req = 0;
    for (int i = 0; i < 2; i++) begin
      id_req = 1; id_pipe = 1; id_pc = 10'(10'h0AA + i);
      tick();
      checks++;
      if (redir_t !== 1'b0) begin
        failures++;
        $display("FAIL hold_drop%0d got=%b exp=0", i, redir_t);
      end
    end
    id_req = 1; id_pipe = 1; id_pc = 10'h0AC;
    tick();
    clear_inputs();
    checks++;
    if ({redir_t, redir_pc_t, flush_ifid_t, flush_idex_t, pipe_valid_t, pipe_valid_n}
        !== {1'b1, 10'h0AC, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL hold_id_issue got rt=%b pct=%h fi=%b fx=%b pvt=%b pvn=%b exp 1 0ac 1 0 0 1",
               redir_t, redir_pc_t, flush_ifid_t, flush_idex_t, pipe_valid_t, pipe_valid_n);
    end
  endtask

  task automatic test_reset_pend();
    settle();
    fetch_stall = 1;
    ex_req = 1; ex_pipe = 1; ex_pc = 10'h1FF;
    tick();
    ex_req = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pend_busy got=%b exp=1", busy);
    end
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if ({busy, pipe_valid_t, pipe_valid_n} !== 3'b011) begin
      failures++;
      $display("FAIL async_reset got=%b exp=011", {busy, pipe_valid_t, pipe_valid_n});
    end
    tick();
    rst = 1;
    fetch_stall = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({redir_t, redir_n, busy, pipe_valid_t, pipe_valid_n} !== 5'b00011) begin
        failures++;
        $display("FAIL reset_pend_discard%0d got=%b exp=00011", i,
                 {redir_t, redir_n, busy, pipe_valid_t, pipe_valid_n});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ex_req      = ($urandom_range(0, 3) == 0);
      ex_pipe     = 1'($urandom);
      ex_pc       = PC_W'($urandom);
      id_req      = ($urandom_range(0, 2) == 0);
      id_pipe     = 1'($urandom);
      id_pc       = PC_W'($urandom);
      fetch_stall = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (observed() !== exp_vec) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, observed(), exp_vec);
      end
    end
    clear_inputs();
`ifdef REDIRECT_STATS_EN
    checks++;
    if ({ex_cnt, id_cnt, drop_cnt} !== {16'(m_ex), 16'(m_id), 16'(m_drop)}) begin
      failures++;
      $display("FAIL random_stats got ex=%0d id=%0d drop=%0d exp ex=%0d id=%0d drop=%0d",
               ex_cnt, id_cnt, drop_cnt, m_ex, m_id, m_drop);
    end
`endif
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_ex_basic();
    test_priority();
    test_stall_overwrite();
    test_hold();
    test_reset_pend();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter PC_W, default 10, PC width in bits.
REQ-002 Parameter HOLD_CYCLES, default 1, cycles for which ID redirects are suppressed after any issued redirect (range 0..3).
REQ-003 clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-004 ex_req  in  1  EX-stage branch correction request; ex_pipe  in  1  target pipe (1=taken pipe T, 0=not-taken pipe N); ex_pc  in  PC_W  correction PC.
REQ-005 id_req  in  1  ID-stage jump redirect request; id_pipe  in  1  target pipe; id_pc  in  PC_W  jump target.
REQ-006 fetch_stall  in  1  fetch cannot accept a redirect this cycle.
REQ-007 redir_t, redir_n  out  1  redirect strobe per pipe; redir_pc_t, redir_pc_n  out  PC_W  redirect PC.
REQ-008 flush_ifid_t, flush_idex_t, flush_ifid_n, flush_idex_n  out  1  per-pipe flush strobes.
REQ-009 pipe_valid_t, pipe_valid_n  out  1  pipe currently holds correct-path instructions.
REQ-010 busy  out  1  a redirect is pending.

Function
REQ-011 All outputs registered; an accepted request appears on outputs exactly 1 cycle later.
REQ-012 Priority: ex_req over id_req; a same-cycle id_req is dropped when ex_req is present, regardless of pipe.
REQ-013 FSM states IDLE, PEND, HOLD; IDLE->PEND on accepted request while fetch_stall=1; IDLE->HOLD on issue; PEND->HOLD when fetch_stall falls (issue); HOLD->IDLE after HOLD_CYCLES cycles; HOLD_CYCLES=0 returns directly to IDLE.
REQ-014 Pending buffer is one entry {pipe, pc, src}; a new ex_req in PEND overwrites it; an id_req in PEND is dropped.
REQ-015 In HOLD, id_req is dropped; ex_req is accepted and restarts the HOLD count.
REQ-016 Issue of an EX redirect on pipe P: redir_P=1, redir_pc_P=pc, flush_ifid_P=flush_idex_P=1, pipe_valid_P=1, pipe_valid of the other pipe=0; all strobes 1 cycle.
REQ-017 Issue of an ID redirect on pipe P: redir_P=1, flush_ifid_P=1 only; flush_idex_P=0; pipe_valid unchanged.
REQ-018 Strobes for the non-target pipe are 0 and its redir_pc is 0.
REQ-019 fetch_stall rising while in HOLD has no effect; a request accepted while stalled is never issued during the stall.
REQ-020 busy=1 exactly in PEND.

Reset
REQ-021 rst low: state IDLE, pending buffer and hold counter cleared, all strobes and PCs 0, pipe_valid_t=pipe_valid_n=1, busy=0.
REQ-022 Reset mid-PEND discards the pending redirect; nothing issues after reset release until a new request arrives.

Configuration
REQ-023 Macro REDIRECT_STATS_EN: when defined, adds outputs ex_cnt, id_cnt, drop_cnt (16 bits each, saturating at 0xFFFF, cleared by rst) counting issued EX redirects, issued ID redirects and dropped/overwritten requests; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-024 Shared package holds the state enum {IDLE, PEND, HOLD}, the pipe-select constants PIPE_T=1 and PIPE_N=0, and the source encoding SRC_EX/SRC_ID.
REQ-025 One sub-module, redirect_pend_buf, implements the one-entry pending buffer with overwrite; the FSM and output registers remain in the top module.

Verification
REQ-026 ex_req=1, ex_pipe=0, ex_pc=0x12A, no stall -> next cycle redir_n=1, redir_pc_n=0x12A, flush_ifid_n=flush_idex_n=1, pipe_valid_n=1, pipe_valid_t=0.
REQ-027 Same cycle ex_req (pipe 1, 0x040) and id_req (pipe 0, 0x300) -> only redir_t with 0x040; drop_cnt increments when REDIRECT_STATS_EN is defined.
REQ-028 fetch_stall=1 for 3 cycles, id_req pipe 1 pc 0x010, then ex_req pipe 1 pc 0x020 during the stall -> busy=1; one cycle after the stall drops, redir_t=1 with 0x020 and no 0x010 issue.
REQ-029 HOLD_CYCLES=2, EX redirect issued, then id_req in each of the next 2 cycles -> both dropped; an id_req in the 3rd cycle issues with flush_ifid only.
REQ-030 Enter PEND, assert rst for 1 cycle, release with fetch_stall=0 -> no redirect strobe, pipe_valid_t=pipe_valid_n=1, busy=0.
